// File: rtl/udp_path_pkg.sv
// ---------------------------------------------------------------------------
// udp_path_pkg
// Types and constants shared by the UDP transmit and receive paths.
//   udp_bpw()         bytes per application word for a given word width
//   udp_cnt_w()       width of a datagram byte counter for a given payload limit
//   udp_tx_state_e    transmit-path FSM encoding (IDLE/HDR/PAY)
//   udp_cfg_t         addressing fields latched for each datagram header
//   UDP_DEFAULT_TTL   default IP time-to-live
//   UDP_MAX_PAYLOAD   default maximum UDP payload per datagram (1500 - 20 - 8)
// ---------------------------------------------------------------------------
package udp_path_pkg;

   localparam int unsigned UDP_DEFAULT_TTL = 64;
   localparam int unsigned UDP_MAX_PAYLOAD = 1472;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHdr  = 2'd1,
      StPay  = 2'd2
   } udp_tx_state_e;

   typedef struct packed {
      logic [31:0] source_ip;
      logic [31:0] dest_ip;
      logic [15:0] source_port;
      logic [15:0] dest_port;
   } udp_cfg_t;

   function automatic int unsigned udp_bpw(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned udp_cnt_w(input int unsigned max_payload);
      return (max_payload > 1) ? $clog2(max_payload) : 1;
   endfunction

endpackage

// File: rtl/udp_tx_path.sv
// ---------------------------------------------------------------------------
// udp_tx_path
// Takes application words (valid/ready/last plus a last-word byte count),
// serialises them LSB byte first, and hands them to the UDP core as a header
// handshake followed by a byte-wide AXI-Stream payload. Packets longer than
// MAX_PAYLOAD bytes are split into several datagrams, each with its own header.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   din_data/valid/ready/last     application word stream
//   din_bytes                     valid bytes in a last word (0 or >BPW = full)
//   tx_udp_hdr_valid/ready        header handshake to the UDP core
//   tx_udp_ip_* / tx_udp_*_port   header fields (config latched per datagram)
//   tx_udp_payload_axis_*         byte-wide payload stream, tlast per datagram
//   local_ip/dest_ip/local_port/dest_port   live configuration inputs
// ---------------------------------------------------------------------------
module udp_tx_path
   import udp_path_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned MAX_PAYLOAD = UDP_MAX_PAYLOAD,
   parameter int unsigned IP_TTL      = UDP_DEFAULT_TTL
) (
   input  logic                         clk,
   input  logic                         rst,

   input  logic [DATA_W-1:0]            din_data,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic                         din_last,
   input  logic [$clog2(DATA_W/8):0]    din_bytes,

   output logic                         tx_udp_hdr_valid,
   input  logic                         tx_udp_hdr_ready,
   output logic [5:0]                   tx_udp_ip_dscp,
   output logic [1:0]                   tx_udp_ip_ecn,
   output logic [7:0]                   tx_udp_ip_ttl,
   output logic [31:0]                  tx_udp_ip_source_ip,
   output logic [31:0]                  tx_udp_ip_dest_ip,
   output logic [15:0]                  tx_udp_source_port,
   output logic [15:0]                  tx_udp_dest_port,

   output logic [7:0]                   tx_udp_payload_axis_tdata,
   output logic                         tx_udp_payload_axis_tvalid,
   input  logic                         tx_udp_payload_axis_tready,
   output logic                         tx_udp_payload_axis_tlast,
   output logic                         tx_udp_payload_axis_tuser,

   input  logic [31:0]                  local_ip,
   input  logic [31:0]                  dest_ip,
   input  logic [15:0]                  local_port,
   input  logic [15:0]                  dest_port
);

   localparam int unsigned BPW = udp_bpw(DATA_W);
   localparam int unsigned NW  = $clog2(BPW) + 1;
   localparam int unsigned CW  = udp_cnt_w(MAX_PAYLOAD);

   localparam logic [NW-1:0] N_FULL   = NW'(BPW);
   localparam logic [NW-1:0] N_ONE    = NW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PAYLOAD - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   // With a one-byte payload limit every byte closes its datagram.
   localparam logic          SEG_ONE  = (MAX_PAYLOAD == 1);

   udp_tx_state_e     state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NW-1:0]     n_q, n_d;
   logic              last_q, last_d;
   logic [NW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sod_q, sod_d;
   udp_cfg_t          cfg_q, cfg_d;
   logic              hdr_valid_q, hdr_valid_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic [7:0]        tdata_q, tdata_d;

   logic [NW-1:0]     din_n;
   udp_cfg_t          cfg_in;
   logic [NW-1:0]     idx_nxt;
   logic [CW-1:0]     cnt_nxt;
   logic              word_end;
   logic              seg_end;

   always_comb begin
      // Only a last word may be short; out-of-range counts mean a full word.
      if (!din_last || (din_bytes == '0) || (din_bytes > N_FULL)) begin
         din_n = N_FULL;
      end else begin
         din_n = din_bytes;
      end
      cfg_in   = {local_ip, dest_ip, local_port, dest_port};
      idx_nxt  = idx_q + N_ONE;
      cnt_nxt  = cnt_q + CNT_ONE;
      word_end = (idx_q == (n_q - N_ONE));
      seg_end  = (cnt_q == CNT_LAST);
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      n_d         = n_q;
      last_d      = last_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      sod_d       = sod_q;
      cfg_d       = cfg_q;
      hdr_valid_d = hdr_valid_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      tdata_d     = tdata_q;
      din_ready   = (state_q == StIdle);

      unique case (state_q)
         StIdle: begin
            if (din_valid) begin
               data_d = din_data;
               n_d    = din_n;
               last_d = din_last;
               idx_d  = '0;
               if (sod_q) begin
                  cfg_d       = cfg_in;
                  hdr_valid_d = 1'b1;
                  state_d     = StHdr;
               end else begin
                  // Continuing a datagram: present byte 0 straight away.
                  tvalid_d = 1'b1;
                  tdata_d  = din_data[7:0];
                  tlast_d  = ((din_n == N_ONE) && din_last) || (cnt_q == CNT_LAST);
                  state_d  = StPay;
               end
            end
         end

         StHdr: begin
            if (tx_udp_hdr_ready) begin
               hdr_valid_d = 1'b0;
               cnt_d       = '0;
               sod_d       = 1'b0;
               tvalid_d    = 1'b1;
               tdata_d     = data_q[{idx_q, 3'b000} +: 8];
               tlast_d     = (word_end && last_q) || SEG_ONE;
               state_d     = StPay;
            end
         end

         StPay: begin
            if (tx_udp_payload_axis_tready) begin
               idx_d = idx_nxt;
               if (word_end) begin
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  cnt_d    = seg_end ? '0 : cnt_nxt;
                  // A packet end or a full datagram means the next word opens a new one.
                  if (last_q || seg_end) begin
                     sod_d = 1'b1;
                  end
                  state_d = StIdle;
               end else if (seg_end) begin
                  // Datagram full mid-word: re-header and resume at the next byte.
                  tvalid_d    = 1'b0;
                  tlast_d     = 1'b0;
                  cnt_d       = '0;
                  cfg_d       = cfg_in;
                  hdr_valid_d = 1'b1;
                  state_d     = StHdr;
               end else begin
                  cnt_d   = cnt_nxt;
                  tdata_d = data_q[{idx_nxt, 3'b000} +: 8];
                  tlast_d = ((idx_nxt == (n_q - N_ONE)) && last_q) || (cnt_nxt == CNT_LAST);
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         data_q      <= '0;
         n_q         <= '0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         cnt_q       <= '0;
         sod_q       <= 1'b1;
         cfg_q       <= '0;
         hdr_valid_q <= 1'b0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         n_q         <= n_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         sod_q       <= sod_d;
         cfg_q       <= cfg_d;
         hdr_valid_q <= hdr_valid_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         tdata_q     <= tdata_d;
      end
   end

   assign tx_udp_hdr_valid           = hdr_valid_q;
   assign tx_udp_ip_dscp             = 6'd0;
   assign tx_udp_ip_ecn              = 2'd0;
   assign tx_udp_ip_ttl              = 8'(IP_TTL);
   assign tx_udp_ip_source_ip        = cfg_q.source_ip;
   assign tx_udp_ip_dest_ip          = cfg_q.dest_ip;
   assign tx_udp_source_port         = cfg_q.source_port;
   assign tx_udp_dest_port           = cfg_q.dest_port;
   assign tx_udp_payload_axis_tdata  = tdata_q;
   assign tx_udp_payload_axis_tvalid = tvalid_q;
   assign tx_udp_payload_axis_tlast  = tlast_q;
   assign tx_udp_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_udp_tx_path.sv
// ---------------------------------------------------------------------------
// tb_udp_tx_path
// Three udp_tx_path instances (MAX_PAYLOAD 1472, 5, 8) share stimulus; sel
// picks the active one. Packet tasks push the expected header/byte sequence
// into a queue; a negedge monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_udp_tx_path;

   typedef struct packed {
      logic        hdr;
      logic [7:0]  data;
      logic        last;
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sp;
      logic [15:0] dp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] din_data = '0;
   logic        din_valid = 1'b0;
   logic        din_last = 1'b0;
   logic [3:0]  din_bytes = '0;
   logic        hdr_ready = 1'b1;
   logic        tready = 1'b1;
   logic [31:0] local_ip = 32'hC0A8_0001;
   logic [31:0] dest_ip = 32'hC0A8_0002;
   logic [15:0] local_port = 16'd1000;
   logic [15:0] dest_port = 16'd2000;
   logic [1:0]  sel = 2'd0;
   bit          rand_rdy = 1'b0;

   logic        din_ready_w [3];
   logic        hdr_valid_w [3];
   logic [5:0]  dscp_w [3];
   logic [1:0]  ecn_w [3];
   logic [7:0]  ttl_w [3];
   logic [31:0] sip_w [3];
   logic [31:0] dip_w [3];
   logic [15:0] sp_w [3];
   logic [15:0] dp_w [3];
   logic [7:0]  tdata_w [3];
   logic        tvalid_w [3];
   logic        tlast_w [3];
   logic        tuser_w [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      udp_tx_path #(
         .DATA_W      (64),
         .MAX_PAYLOAD ((g == 0) ? 1472 : ((g == 1) ? 5 : 8)),
         .IP_TTL      (64)
      ) u_dut (
         .clk                        (clk),
         .rst                        (rst),
         .din_data                   (din_data),
         .din_valid                  (din_valid && (sel == 2'(g))),
         .din_ready                  (din_ready_w[g]),
         .din_last                   (din_last),
         .din_bytes                  (din_bytes),
         .tx_udp_hdr_valid           (hdr_valid_w[g]),
         .tx_udp_hdr_ready           (hdr_ready),
         .tx_udp_ip_dscp             (dscp_w[g]),
         .tx_udp_ip_ecn              (ecn_w[g]),
         .tx_udp_ip_ttl              (ttl_w[g]),
         .tx_udp_ip_source_ip        (sip_w[g]),
         .tx_udp_ip_dest_ip          (dip_w[g]),
         .tx_udp_source_port         (sp_w[g]),
         .tx_udp_dest_port           (dp_w[g]),
         .tx_udp_payload_axis_tdata  (tdata_w[g]),
         .tx_udp_payload_axis_tvalid (tvalid_w[g]),
         .tx_udp_payload_axis_tready (tready),
         .tx_udp_payload_axis_tlast  (tlast_w[g]),
         .tx_udp_payload_axis_tuser  (tuser_w[g]),
         .local_ip                   (local_ip),
         .dest_ip                    (dest_ip),
         .local_port                 (local_port),
         .dest_port                  (dest_port)
      );
   end

   logic        m_din_ready, m_hdr_valid, m_tvalid, m_tlast, m_tuser;
   logic [5:0]  m_dscp;
   logic [1:0]  m_ecn;
   logic [7:0]  m_ttl, m_tdata;
   logic [31:0] m_sip, m_dip;
   logic [15:0] m_sp, m_dp;

   assign m_din_ready = din_ready_w[sel];
   assign m_hdr_valid = hdr_valid_w[sel];
   assign m_tvalid    = tvalid_w[sel];
   assign m_tlast     = tlast_w[sel];
   assign m_tuser     = tuser_w[sel];
   assign m_dscp      = dscp_w[sel];
   assign m_ecn       = ecn_w[sel];
   assign m_ttl       = ttl_w[sel];
   assign m_tdata     = tdata_w[sel];
   assign m_sip       = sip_w[sel];
   assign m_dip       = dip_w[sel];
   assign m_sp        = sp_w[sel];
   assign m_dp        = dp_w[sel];

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   bytes_seen = 0;

   always @(posedge clk) begin
      #1;
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: a handshake seen at negedge completes on the following posedge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (m_hdr_valid && hdr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL hdr_unexpected got sport=%h dport=%h required none", m_sp, m_dp);
            end else begin
               e = exp_q.pop_front();
               if (!e.hdr || ({m_sip, m_dip, m_sp, m_dp, m_ttl, m_dscp, m_ecn} !==
                              {e.sip, e.dip, e.sp, e.dp, 8'd64, 6'd0, 2'd0})) begin
                  errors++;
                  $display("FAIL header got hdr sip=%h dip=%h sp=%h dp=%h ttl=%h required hdr=%0b sip=%h dip=%h sp=%h dp=%h ttl=40",
                           m_sip, m_dip, m_sp, m_dp, m_ttl, e.hdr, e.sip, e.dip, e.sp, e.dp);
               end
            end
         end
         if (m_tvalid && tready) begin
            checks++;
            bytes_seen++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL byte_unexpected got data=%h last=%0b required none", m_tdata, m_tlast);
            end else begin
               e = exp_q.pop_front();
               if (e.hdr || ({m_tdata, m_tlast, m_tuser} !== {e.data, e.last, 1'b0})) begin
                  errors++;
                  $display("FAIL byte got data=%h last=%0b user=%0b required hdr=%0b data=%h last=%0b user=0",
                           m_tdata, m_tlast, m_tuser, e.hdr, e.data, e.last);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   function automatic int maxp(input logic [1:0] s);
      return (s == 2'd0) ? 1472 : ((s == 2'd1) ? 5 : 8);
   endfunction

   task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb,
                            output bit ok);
      din_data  = d;
      din_last  = last;
      din_bytes = nb;
      din_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (m_din_ready) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         errors++;
         $display("FAIL word_accept got=timeout required=accept");
      end
      din_valid = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [7:0] start, input int alt);
      int          m;
      int          nw;
      exp_t        e;
      logic [63:0] w;
      logic [3:0]  nb;
      bit          ok;
      m  = maxp(sel);
      nw = (n + 7) / 8;
      for (int i = 0; i < n; i++) begin
         if (i % m == 0) begin
            e = '0;
            e.hdr = 1'b1;
            e.sip = local_ip;
            e.dip = dest_ip;
            e.sp  = local_port;
            e.dp  = dest_port;
            exp_q.push_back(e);
         end
         e = '0;
         e.data = start + 8'(i);
         e.last = (i == n - 1) || (i % m == m - 1);
         exp_q.push_back(e);
      end
      for (int k = 0; k < nw; k++) begin
         for (int b = 0; b < 8; b++) begin
            w[8*b +: 8] = (8 * k + b < n) ? start + 8'(8 * k + b) : 8'hEE;
         end
         if (k == nw - 1) nb = (alt >= 0) ? 4'(alt) : 4'(n - 8 * k);
         else             nb = 4'd3;  // ignored on non-last words
         send_word(w, k == nw - 1, nb, ok);
         if (k == 0 && ok) check("hdr_latency", 64'(m_hdr_valid), 64'd1);
      end
   endtask

   task automatic drain(input string name);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 3000) begin
         @(posedge clk);
         #1;
         i++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      check({name, "_idle"}, 64'({m_din_ready, m_hdr_valid, m_tvalid}), 64'b100);
   endtask

   initial begin
      int b0;
      int i;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check("reset_ctrl", 64'({m_din_ready, m_hdr_valid, m_tvalid, m_tlast, m_tdata}),
               64'({4'b1000, 8'h00}));
         check("reset_ip", {m_sip, m_dip}, 64'd0);
         check("reset_port", 64'({m_sp, m_dp}), 64'd0);
      end
      sel = 2'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // MAX_PAYLOAD 1472
      send_pkt(8, 8'h01, -1);   drain("single_word");
      send_pkt(11, 8'h11, -1);  drain("two_word");
      send_pkt(8, 8'h40, 0);    drain("bytes_zero");
      send_pkt(16, 8'h50, 15);  drain("bytes_over");

      // MAX_PAYLOAD 5
      sel = 2'd1;
      send_pkt(8, 8'h01, -1);   drain("seg5_8");
      send_pkt(10, 8'h20, -1);  drain("seg5_10");
      send_pkt(5, 8'h30, -1);   drain("seg5_5");
      send_pkt(48, 8'h80, -1);  drain("seg5_48");

      // MAX_PAYLOAD 8
      sel = 2'd2;
      send_pkt(16, 8'hC0, -1);  drain("seg8_16");
      send_pkt(8, 8'hD0, -1);   drain("seg8_8");

      // Header held off while the config changes underneath it
      sel = 2'd0;
      hdr_ready  = 1'b0;
      local_port = 16'd1234;
      send_pkt(8, 8'h60, -1);
      local_port = 16'd5678;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 64'(m_hdr_valid), 64'd1);
         check("hold_port", 64'(m_sp), 64'd1234);
      end
      hdr_ready = 1'b1;
      drain("hold");

      // Random payload back-pressure
      rand_rdy = 1'b1;
      sel = 2'd1;
      send_pkt(24, 8'h70, -1);  drain("rand_seg5");
      sel = 2'd0;
      send_pkt(20, 8'h90, -1);  drain("rand_1472");
      rand_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-payload
      b0 = bytes_seen;
      send_pkt(8, 8'hA0, -1);
      i = 0;
      while (bytes_seen < b0 + 3 && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("rst_midpay_reached", 64'(bytes_seen >= b0 + 3), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_valids", 64'({m_hdr_valid, m_tvalid, m_tlast, m_din_ready}), 64'b0001);
      rst = 1'b0;
      exp_q.delete();
      local_ip  = 32'h0A00_0005;
      dest_port = 16'd4321;
      send_pkt(8, 8'hB0, -1);   drain("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_tx_path.md
# udp_tx_path

Transmit-side counterpart of the UDP receive path. It accepts application words of DATA_W bits with valid/ready/last and a final-word byte count. It serialises each word into bytes, least-significant byte first, matching the byte order used on receive. It then emits a UDP header handshake followed by a byte-wide AXI-Stream payload to the UDP core, splitting long application packets into datagrams of at most MAX_PAYLOAD bytes. Single clock domain; any clock-domain crossing from the application side is done by an external axis_async_fifo.

## Interface
Parameters:
- DATA_W, 64, application word width; multiple of 8, 16..128.
- MAX_PAYLOAD, 1472, maximum UDP payload bytes per datagram; ≥ 1.
- IP_TTL, 64, value driven on tx_udp_ip_ttl.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- din_data  in  DATA_W  word; byte k = bits [8k+7:8k], byte 0 sent first.
- din_valid  in  1  word valid.
- din_ready  out  1  word accepted when din_valid && din_ready.
- din_last  in  1  word ends the application packet.
- din_bytes  in  clog2(DATA_W/8)+1  valid bytes in a last word; ignored when din_last=0.
- tx_udp_hdr_valid  out  1  header valid.
- tx_udp_hdr_ready  in  1  header accepted.
- tx_udp_ip_dscp  out  6  constant 0.
- tx_udp_ip_ecn  out  2  constant 0.
- tx_udp_ip_ttl  out  8  IP_TTL.
- tx_udp_ip_source_ip  out  32  latched local_ip.
- tx_udp_ip_dest_ip  out  32  latched dest_ip.
- tx_udp_source_port  out  16  latched local_port.
- tx_udp_dest_port  out  16  latched dest_port.
- tx_udp_payload_axis_tdata  out  8  payload byte.
- tx_udp_payload_axis_tvalid  out  1  byte valid.
- tx_udp_payload_axis_tready  in  1  byte accepted.
- tx_udp_payload_axis_tlast  out  1  last byte of datagram.
- tx_udp_payload_axis_tuser  out  1  constant 0.
- local_ip, dest_ip  in  32  configuration.
- local_port, dest_port  in  16  configuration.

## Operation
- BPW = DATA_W/8. Non-last words always carry BPW bytes. On a last word, a din_bytes value of 0 or greater than BPW is treated as BPW.
- State: word buffer (data, byte count n, last flag), byte index idx, datagram byte counter cnt (0..MAX_PAYLOAD-1), start-of-datagram flag sod. sod=1 after reset.
- States:
  - IDLE: buffer empty.
  - HDR: tx_udp_hdr_valid=1.
  - PAY: tx_udp_payload_axis_tvalid=1, tdata = buffer byte idx.
- IDLE: din_ready=1. On accept, load the buffer and set idx=0. If sod=1, latch the four config fields and go to HDR; otherwise go to PAY.
- HDR: on tx_udp_hdr_ready, set cnt=0, clear sod, go to PAY. Header fields are stable from hdr_valid rise until the handshake.
- PAY: tlast = (idx==n-1 && last flag) || cnt==MAX_PAYLOAD-1. On each byte handshake, idx and cnt increment, and then:
  - Word exhausted and packet end: go to IDLE, set sod=1.
  - Word exhausted and segment boundary (cnt==MAX_PAYLOAD-1): go to IDLE, set sod=1.
  - Word exhausted otherwise: go to IDLE, sod unchanged.
  - Segment boundary with bytes remaining: latch config again and go to HDR. The next datagram continues from byte idx+1.
- Packet end and segment boundary on the same byte produce a single tlast and no empty datagram.
- din_ready=0 in HDR and PAY.
- Length and checksum fields are not produced here; the downstream UDP core generates them.

## Timing
- Reset values:
  - din_ready=1, tx_udp_hdr_valid=0, tx_udp_payload_axis_tvalid=0, tlast=0.
  - Latched IP/port fields = 0, tdata=0.
  - State IDLE, sod=1, cnt=0, idx=0.
- All outputs are registered except din_ready, which decodes state only.
- Word accepted at edge t:
  - Header valid from cycle t+1 (sod=1), or first byte valid from t+1 (sod=0).
  - After a header handshake at edge h, first byte valid from h+1.
- Streams one byte per cycle while tready=1. One idle cycle per word refill, so a full word costs BPW+1 cycles.
- Valid outputs hold their value and stay asserted until the handshake; no retraction.
- Config changes take effect only at the next header latch.
- rst asserted mid-packet: the buffer is discarded, the in-flight datagram is abandoned without tlast, and the block returns to the reset values on the next cycle.

## Structure
- Shared package udp_path_pkg holds:
  - BPW computation.
  - State encoding (IDLE/HDR/PAY).
  - Default TTL and MAX_PAYLOAD constants, also usable by udp_rx_path.
- Single module, no sub-modules. The application-side async FIFO is instantiated by the parent.

## Test plan
- DATA_W=64, one word 0x0807060504030201, din_last=1, din_bytes=8 -> one header, bytes 01..08, tlast on 08, returns to IDLE.
- Two words, the second with din_last=1 and din_bytes=3 -> one header, 11 bytes, tlast on byte 11. Padding bytes of the second word are never emitted.
- MAX_PAYLOAD=5, one 8-byte last word -> header, 5 bytes with tlast on the 5th, second header, 3 bytes with tlast.
- MAX_PAYLOAD=8, 16-byte packet -> two datagrams of 8 bytes each, no empty datagram. Same check with a packet of exactly 8 bytes -> one datagram, one tlast.
- tx_udp_hdr_ready held low 10 cycles while local_port changes from 1234 to 5678 -> hdr_valid stays high and the port stays 1234. A randomly toggled payload tready gives no lost or duplicated bytes.
- rst pulsed mid-payload -> all valids low the next cycle. The following packet starts with a fresh header carrying the current config.
